// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: EX->ID ALU and load-use bubbles, branch squash, data-memory freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_controller #(
    parameter int DATA_WIDTH        = 32,
    parameter int LOAD_STALL_CYCLES = 2,
    parameter int ALU_STALL_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1ID,
    input  logic [4:0] rs2ID,
    input  logic       useRs1ID,
    input  logic       useRs2ID,
    input  logic [4:0] rdEX,
    input  logic       regWriteEX,
    input  logic       memReadEX,
    input  logic       branchTakenEX,
    input  logic       memReqMEM,
    input  logic       memReadyMEM,
    output logic       pcWrite,
    output logic       ifIdWrite,
    output logic       idExWrite,
    output logic       exMemWrite,
    output logic       ifIdFlush,
    output logic       idExFlush,
    output logic       memWbBubble,
    output logic       stalled
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0] loadStallCnt,
    output logic [DATA_WIDTH-1:0] memFreezeCnt,
    output logic [DATA_WIDTH-1:0] flushCnt
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] LOAD_N = 2'(LOAD_STALL_CYCLES);
    localparam logic [1:0] ALU_N  = 2'(ALU_STALL_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic       mem_freeze;
    logic       rs1_hit, rs2_hit, match;
    logic       load_haz, alu_haz;
    logic [1:0] haz_n;
    logic       do_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic                  load_stall_q, load_stall_d;
    logic                  load_bubble;
    logic [DATA_WIDTH-1:0] load_cnt_q, load_cnt_d;
    logic [DATA_WIDTH-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [DATA_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
`endif

    // Dependency check between the ID consumer and the EX producer; x0 never counts.
    always_comb begin
        mem_freeze = memReqMEM & ~memReadyMEM;
        rs1_hit    = useRs1ID & (rs1ID == rdEX);
        rs2_hit    = useRs2ID & (rs2ID == rdEX);
        match      = (rdEX != 5'd0) & regWriteEX & (rs1_hit | rs2_hit);
        load_haz   = match & memReadEX;
        alu_haz    = match & ~memReadEX;
        if (load_haz) begin
            haz_n = LOAD_N;
        end else if (alu_haz) begin
            haz_n = ALU_N;
        end else begin
            haz_n = 2'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        do_stall    = 1'b0;
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        exMemWrite  = 1'b1;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        memWbBubble = 1'b0;
        stalled     = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        load_stall_d = load_stall_q;
        load_bubble  = 1'b0;
`endif

        if (mem_freeze) begin
            // Whole pipe holds; only MEM/WB gets a bubble so WB never retires stale data twice.
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExWrite   = 1'b0;
            exMemWrite  = 1'b0;
            memWbBubble = 1'b1;
            stalled     = 1'b1;
        end else if (branchTakenEX) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            state_d   = RUN;
            cnt_d     = 2'd0;
        end else if (state_q == STALL) begin
            do_stall = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
            load_bubble = load_stall_q;
`endif
            if (cnt_q <= 2'd1) begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (haz_n != 2'd0) begin
            // This cycle is already bubble #1; STALL only covers the remaining N-1.
            do_stall = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
            load_bubble = load_haz;
`endif
            if (haz_n >= 2'd2) begin
                state_d = STALL;
                cnt_d   = haz_n - 2'd1;
`ifdef HAZARD_PERF_CNT_EN
                load_stall_d = load_haz;
`endif
            end
        end

        if (do_stall) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
            stalled   = 1'b1;
        end

        if (rst) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExWrite   = 1'b0;
            exMemWrite  = 1'b0;
            ifIdFlush   = 1'b1;
            idExFlush   = 1'b1;
            memWbBubble = 1'b1;
            stalled     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_comb begin
        load_cnt_d   = load_cnt_q + DATA_WIDTH'(load_bubble);
        freeze_cnt_d = freeze_cnt_q + DATA_WIDTH'(mem_freeze);
        flush_cnt_d  = flush_cnt_q + DATA_WIDTH'(branchTakenEX & ~mem_freeze);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_stall_q <= 1'b0;
            load_cnt_q   <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            load_stall_q <= load_stall_d;
            load_cnt_q   <= load_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign loadStallCnt = load_cnt_q;
    assign memFreezeCnt = freeze_cnt_q;
    assign flushCnt     = flush_cnt_q;
`else
    // DATA_WIDTH only sizes the counters; fold it into a sink so the default build stays clean.
    logic unused_params;
    assign unused_params = |DATA_WIDTH;
`endif

endmodule
